// File: rtl/dpwm_counter_gen2.sv
// dpwm_counter_gen2 - counter-based digital PWM for the buck converter PID loop.
//
// A WIDTH-bit up-counter defines a PWM period of 2^WIDTH clk cycles. Duty
// commands land in a shadow register and move into the active compare
// register only at the period boundary (or continuously while disabled), so
// a mid-period compensator update can never produce a runt pulse.
//
// Optional feature macro: DPWM_DEADTIME_EN
//   defined   : DEAD-cycle dead time inserted on the rising edge of each gate,
//               pulses of DEAD cycles or fewer are swallowed for that side.
//   undefined : duty = registered raw compare, duty_n = registered en & ~raw.
//
// Parameters:
//   WIDTH  counter/duty width, period = 2^WIDTH cycles
//   DMIN   lower duty clamp (high cycles per period)
//   DMAX   upper duty clamp, DMIN <= DMAX <= 2^WIDTH-1
//   DEAD   dead-time cycles per edge, 1..2^(WIDTH-2) (dead-time build only)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   en            run enable; count held at 0 and gates off while low
//   d_n_input     duty command from the compensator
//   d_valid       one-cycle strobe capturing d_n_input into the shadow
//   duty          high-side gate drive (registered)
//   duty_n        low-side gate drive (registered)
//   period_start  one-cycle pulse at the start of each PWM period
//   d_loaded      one-cycle pulse when the shadow transfers at a boundary

module dpwm_counter_gen2 #(
    parameter int WIDTH = 9,
    parameter int DMIN  = 0,
    parameter int DMAX  = (1 << WIDTH) - 1,
    parameter int DEAD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d_n_input,
    input  logic             d_valid,
    output logic             duty,
    output logic             duty_n,
    output logic             period_start,
    output logic             d_loaded
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] DMIN_V  = WIDTH'(DMIN);
    localparam logic [WIDTH-1:0] DMAX_V  = WIDTH'(DMAX);

    function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] x);
        if (x < DMIN_V) begin
            return DMIN_V;
        end else if (x > DMAX_V) begin
            return DMAX_V;
        end else begin
            return x;
        end
    endfunction

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] active_q, active_d;
    logic             duty_q, duty_d;
    logic             duty_n_q, duty_n_d;
    logic             period_start_q, period_start_d;
    logic             d_loaded_q, d_loaded_d;
    logic             at_end;
    logic             raw;

`ifdef DPWM_DEADTIME_EN
    localparam logic [WIDTH-1:0] DEAD_V = WIDTH'(DEAD);

    // Length of the current raw-high / raw-low run, saturating at DEAD.
    logic [WIDTH-1:0] hi_run_q, hi_run_d;
    logic [WIDTH-1:0] lo_run_q, lo_run_d;
`endif

    always_comb begin
        at_end = (count_q == CNT_MAX);

        count_d = en ? (count_q + 1'b1) : '0;

        shadow_d = d_valid ? d_n_input : shadow_q;

        // shadow_d already carries a same-cycle d_valid, which gives the
        // bypass when a command arrives exactly on the boundary.
        active_d   = (!en || at_end) ? clamp_duty(shadow_d) : active_q;
        d_loaded_d = en & at_end;

        raw            = en & (count_q < active_q);
        period_start_d = en & (count_q == '0);

`ifdef DPWM_DEADTIME_EN
        hi_run_d = '0;
        lo_run_d = '0;
        if (raw) begin
            hi_run_d = (hi_run_q >= DEAD_V) ? hi_run_q : hi_run_q + 1'b1;
        end
        if (en && !raw) begin
            lo_run_d = (lo_run_q >= DEAD_V) ? lo_run_q : lo_run_q + 1'b1;
        end
        // A side turns on only once its raw run has already lasted DEAD
        // cycles; runs no longer than DEAD never get there.
        duty_d   = raw & (hi_run_q >= DEAD_V);
        duty_n_d = en & ~raw & (lo_run_q >= DEAD_V);
`else
        duty_d   = raw;
        duty_n_d = en & ~raw;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q        <= '0;
            shadow_q       <= '0;
            active_q       <= '0;
            duty_q         <= 1'b0;
            duty_n_q       <= 1'b0;
            period_start_q <= 1'b0;
            d_loaded_q     <= 1'b0;
`ifdef DPWM_DEADTIME_EN
            hi_run_q       <= '0;
            lo_run_q       <= '0;
`endif
        end else begin
            count_q        <= count_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            duty_q         <= duty_d;
            duty_n_q       <= duty_n_d;
            period_start_q <= period_start_d;
            d_loaded_q     <= d_loaded_d;
`ifdef DPWM_DEADTIME_EN
            hi_run_q       <= hi_run_d;
            lo_run_q       <= lo_run_d;
`endif
        end
    end

    assign duty         = duty_q;
    assign duty_n       = duty_n_q;
    assign period_start = period_start_q;
    assign d_loaded     = d_loaded_q;

endmodule

// File: doc/dpwm_counter_gen2.md
# dpwm_counter_gen2

Second-generation counter-based digital PWM for the buck converter's PID loop. Period width, duty limits and dead time are parametrised. Duty commands are double-buffered and applied only at period boundaries, so mid-period PID updates cannot cause glitches. A complementary low-side gate output and a period-start strobe are provided for ADC sampling and compensator triggering.

## Interface
- WIDTH, 9, counter/duty width; PWM period = 2^WIDTH clk cycles
- DMIN, 0, lower duty clamp (cycles high per period)
- DMAX, 2^WIDTH-1, upper duty clamp; DMIN <= DMAX <= 2^WIDTH-1 required
- DEAD, 4, dead-time cycles per edge (used only with DPWM_DEADTIME_EN), 1..2^(WIDTH-2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- d_n_input  in  WIDTH  duty command from compensator (unsigned)
- d_valid  in  1  one-cycle strobe; captures d_n_input into shadow register
- duty  out  1  high-side gate drive (registered)
- duty_n  out  1  low-side gate drive (registered)
- period_start  out  1  one-cycle pulse at start of every PWM period
- d_loaded  out  1  one-cycle pulse when shadow value transfers to active

## Operation
- Reset: count=0, shadow=0, active=0; duty, duty_n, period_start, d_loaded all 0.
- Counter: with en=1, count increments 0 .. 2^WIDTH-1, then wraps to 0. With en=0, count is forced to 0.
- Shadow: loads d_n_input on any cycle with d_valid=1. This happens regardless of en.
- Clamp: clamp(x) = DMIN if x<DMIN, DMAX if x>DMAX, else x. Clamping is applied on transfer to active.
- Transfer: active <= clamp(shadow) when en=1 and count==2^WIDTH-1, and on every cycle with en=0. d_loaded pulses on the en=1 transfer only.
- Simultaneous d_valid and transfer: the incoming d_n_input bypasses into active (clamped) and shadow in the same cycle.
- Comparator: raw = en & (count < active). raw is high for exactly `active` cycles per period. active=0 keeps raw low all period; 2^WIDTH-1 gives a single low cycle per period.
- period_start: registered from (en & count==0).
- With en=0, duty, duty_n and period_start are all 0. Both switches are off.

## Timing
- All outputs are registered and reflect the counter state of the previous cycle (1-cycle latency).
- period_start and the duty rising edge occur in the same cycle.
- A duty command takes effect from the next period boundary. Worst-case latency from d_valid to the new duty at the output is 2^WIDTH+1 cycles.
- en rising: the first period_start appears 1 cycle after the first en=1 cycle, using the latest clamped shadow.
- en falling or rst mid-period: outputs drop to 0 on the next edge. No partial-period completion.
- Wrap: count 2^WIDTH-1 -> 0 with no idle cycle, so the period is exactly 2^WIDTH cycles.

## Configuration
- DPWM_DEADTIME_EN defined:
  - duty rises DEAD cycles after raw rises and falls with raw.
  - duty_n rises DEAD cycles after raw falls and falls with raw rising. duty_n is held 0 while en=0 or rst.
  - A high or low pulse of DEAD cycles or fewer is suppressed for that side.
  - duty & duty_n is never 1.
- DPWM_DEADTIME_EN undefined:
  - duty = registered raw.
  - duty_n = registered (en & ~raw).
  - The DEAD parameter is ignored.

## Test plan
- WIDTH=4, DMIN=0, DMAX=15, rst then en=1, d_n_input=5 with d_valid -> from the next period, duty is high 5 of every 16 cycles and period_start pulses every 16 cycles, coincident with the duty rise.
- Mid-period update: active=5, d_valid with 10 at count=3 -> the current period keeps 5 high cycles, the next period has 10. d_loaded pulses once at the boundary.
- Clamping with DMIN=2, DMAX=12: commands 0 and 15 -> 2 and 12 high cycles respectively. Command 0 without clamp (DMIN=0) -> duty stays low all period.
- d_valid=1 exactly at count=15 with value 7 -> the following period has 7 high cycles (bypass).
- en dropped at count=8, then rst pulsed mid-period -> all outputs 0 on the next edge. Re-enable -> period_start after 1 cycle and count restarts at 0.
- DPWM_DEADTIME_EN, DEAD=2, active=6 -> duty high 4 cycles, duty_n high 8 cycles per period. Never both high. active=2 -> duty suppressed.
